// File: rtl/wb_arbiter_pkg.sv
// Shared writeback-port definitions: default field widths and source IDs.
// No logic; constants only.
// Imported by the arbiter and its skid buffers.
package wb_arbiter_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int RA_W_DEF  = 5;
  localparam int CNT_W_DEF = 64;

  // Source identifiers reported on ret_src and held in last_grant.
  localparam logic SRC_IP  = 1'b0;
  localparam logic SRC_LSP = 1'b1;

endpackage

// File: rtl/wb_skid.sv
// One-entry skid buffer for a writeback result port; exposes a head (buffer or bypass).
// Latency 0 when the head is granted on arrival, otherwise held until granted.
// ready = !full, straight from a flop, so there is no valid-to-ready combinational path.
module wb_skid
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] dst,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] pc,
  input  logic            wb_en,
  input  logic            valid,
  output logic            ready,
  output logic            head_valid,
  output logic [RA_W-1:0] head_dst,
  output logic [XLEN-1:0] head_result,
  output logic [XLEN-1:0] head_pc,
  output logic            head_wb_en,
  input  logic            grant
);

  logic            full;
  logic [RA_W-1:0] buf_dst;
  logic [XLEN-1:0] buf_result;
  logic [XLEN-1:0] buf_pc;
  logic            buf_wb_en;
  logic            xfer;

  assign ready = !full;
  assign xfer  = valid && !full;

  // Head is the buffered entry when present, otherwise whatever transfers this cycle.
  always_comb begin
    head_valid  = full || xfer;
    head_dst    = full ? buf_dst    : dst;
    head_result = full ? buf_result : result;
    head_pc     = full ? buf_pc     : pc;
    head_wb_en  = full ? buf_wb_en  : wb_en;
  end

  // Occupancy: fill on an ungranted transfer, drain when the buffered entry is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
    end else if (full) begin
      if (grant) full <= 1'b0;
    end else if (xfer && !grant) begin
      full <= 1'b1;
    end
  end

  // Capture the payload of a transfer that lost arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_dst    <= '0;
      buf_result <= '0;
      buf_pc     <= '0;
      buf_wb_en  <= 1'b0;
    end else if (xfer && !grant) begin
      buf_dst    <= dst;
      buf_result <= result;
      buf_pc     <= pc;
      buf_wb_en  <= wb_en;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between integer pipe (A) and load/store pipe (B).
// Latency 1 from head presentation to register-file / retire outputs.
// Output stage never stalls; losing port is parked in its skid buffer and drops ready.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RA_W-1:0]  a_dst,
  input  logic [XLEN-1:0]  a_result,
  input  logic [XLEN-1:0]  a_pc,
  input  logic             a_wb_en,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [RA_W-1:0]  b_dst,
  input  logic [XLEN-1:0]  b_result,
  input  logic [XLEN-1:0]  b_pc,
  input  logic             b_wb_en,
  input  logic             b_valid,
  output logic             b_ready,
  output logic             rf_wen,
  output logic [RA_W-1:0]  rf_wdst,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             sb_clr,
  output logic [RA_W-1:0]  sb_clr_dst,
  output logic             ret_valid,
  output logic [XLEN-1:0]  ret_pc,
  output logic             ret_src,
  output logic [CNT_W-1:0] ret_count
);

  logic            a_head_valid, b_head_valid;
  logic [RA_W-1:0] a_head_dst, b_head_dst;
  logic [XLEN-1:0] a_head_result, b_head_result;
  logic [XLEN-1:0] a_head_pc, b_head_pc;
  logic            a_head_wb_en, b_head_wb_en;

  logic            grant_a, grant_b, grant_any;
  logic            last_grant;
  logic [RA_W-1:0] win_dst;
  logic [XLEN-1:0] win_result;
  logic [XLEN-1:0] win_pc;
  logic            win_wb_en;
  logic            win_src;
  logic            win_writes;

  wb_skid #(.XLEN(XLEN), .RA_W(RA_W)) u_skid_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .dst         (a_dst),
    .result      (a_result),
    .pc          (a_pc),
    .wb_en       (a_wb_en),
    .valid       (a_valid),
    .ready       (a_ready),
    .head_valid  (a_head_valid),
    .head_dst    (a_head_dst),
    .head_result (a_head_result),
    .head_pc     (a_head_pc),
    .head_wb_en  (a_head_wb_en),
    .grant       (grant_a)
  );

  wb_skid #(.XLEN(XLEN), .RA_W(RA_W)) u_skid_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .dst         (b_dst),
    .result      (b_result),
    .pc          (b_pc),
    .wb_en       (b_wb_en),
    .valid       (b_valid),
    .ready       (b_ready),
    .head_valid  (b_head_valid),
    .head_dst    (b_head_dst),
    .head_result (b_head_result),
    .head_pc     (b_head_pc),
    .head_wb_en  (b_head_wb_en),
    .grant       (grant_b)
  );

  // Round-robin pick: a lone head wins; on contention the port not granted last time wins.
  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    win_dst    = a_head_dst;
    win_result = a_head_result;
    win_pc     = a_head_pc;
    win_wb_en  = a_head_wb_en;
    win_src    = SRC_IP;
    if (a_head_valid && b_head_valid) begin
      if (last_grant == SRC_LSP) grant_a = 1'b1;
      else                       grant_b = 1'b1;
    end else if (a_head_valid) begin
      grant_a = 1'b1;
    end else if (b_head_valid) begin
      grant_b = 1'b1;
    end
    if (grant_b) begin
      win_dst    = b_head_dst;
      win_result = b_head_result;
      win_pc     = b_head_pc;
      win_wb_en  = b_head_wb_en;
      win_src    = SRC_LSP;
    end
  end

  assign grant_any  = grant_a || grant_b;
  assign win_writes = win_wb_en && (win_dst != '0);

  // Remember who won last; resets to B so A takes the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_grant <= SRC_LSP;
    else if (grant_any) last_grant <= win_src;
  end

  // Registered output slot: pulses follow the grant, data fields hold between grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_valid  <= 1'b0;
      rf_wen     <= 1'b0;
      sb_clr     <= 1'b0;
      rf_wdst    <= '0;
      rf_wdata   <= '0;
      sb_clr_dst <= '0;
      ret_pc     <= '0;
      ret_src    <= SRC_IP;
      ret_count  <= '0;
    end else begin
      ret_valid <= grant_any;
      rf_wen    <= grant_any && win_writes;
      sb_clr    <= grant_any && win_writes;
      if (grant_any) begin
        rf_wdst    <= win_dst;
        rf_wdata   <= win_result;
        sb_clr_dst <= win_dst;
        ret_pc     <= win_pc;
        ret_src    <= win_src;
        ret_count  <= ret_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a randomized run
// against a queue-based round-robin reference model.
// A second instance with a 4-bit retire counter checks counter wrap.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  a_dst, b_dst;
  logic [63:0] a_result, b_result, a_pc, b_pc;
  logic        a_wb_en, b_wb_en, a_valid, b_valid;
  logic        a_ready, b_ready;
  logic        rf_wen, sb_clr, ret_valid, ret_src;
  logic [4:0]  rf_wdst, sb_clr_dst;
  logic [63:0] rf_wdata, ret_pc, ret_count;

  logic        d4_a_ready, d4_b_ready, d4_rf_wen, d4_sb_clr, d4_ret_valid, d4_ret_src;
  logic [4:0]  d4_rf_wdst, d4_sb_clr_dst;
  logic [63:0] d4_rf_wdata, d4_ret_pc;
  logic [3:0]  d4_ret_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] pc;
    logic        wb_en;
  } beat_t;

  always #5 clk = ~clk;

  wb_arbiter #(.XLEN(64), .RA_W(5), .CNT_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_dst(a_dst), .a_result(a_result), .a_pc(a_pc), .a_wb_en(a_wb_en),
    .a_valid(a_valid), .a_ready(a_ready),
    .b_dst(b_dst), .b_result(b_result), .b_pc(b_pc), .b_wb_en(b_wb_en),
    .b_valid(b_valid), .b_ready(b_ready),
    .rf_wen(rf_wen), .rf_wdst(rf_wdst), .rf_wdata(rf_wdata),
    .sb_clr(sb_clr), .sb_clr_dst(sb_clr_dst),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_src(ret_src), .ret_count(ret_count)
  );

  wb_arbiter #(.XLEN(64), .RA_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_dst(a_dst), .a_result(a_result), .a_pc(a_pc), .a_wb_en(a_wb_en),
    .a_valid(a_valid), .a_ready(d4_a_ready),
    .b_dst(b_dst), .b_result(b_result), .b_pc(b_pc), .b_wb_en(b_wb_en),
    .b_valid(b_valid), .b_ready(d4_b_ready),
    .rf_wen(d4_rf_wen), .rf_wdst(d4_rf_wdst), .rf_wdata(d4_rf_wdata),
    .sb_clr(d4_sb_clr), .sb_clr_dst(d4_sb_clr_dst),
    .ret_valid(d4_ret_valid), .ret_pc(d4_ret_pc), .ret_src(d4_ret_src),
    .ret_count(d4_ret_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    a_valid = 1'b0; b_valid = 1'b0;
    a_dst = '0; a_result = '0; a_pc = '0; a_wb_en = 1'b0;
    b_dst = '0; b_result = '0; b_pc = '0; b_wb_en = 1'b0;
  endtask

  task automatic do_reset;
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    string       nm [10];
    logic [63:0] g  [10];
    logic [63:0] w  [10];
    do_reset();
    // One A beat so last_grant = A, then contention parks the next A beat.
    a_valid = 1; a_dst = 5'd3; a_pc = 64'h100; a_result = 64'h11; a_wb_en = 1;
    tick();
    a_pc = 64'h200; a_result = 64'h22;
    b_valid = 1; b_dst = 5'd4; b_pc = 64'h300; b_result = 64'h33; b_wb_en = 1;
    tick();
    drive_idle();
    n_cmp++;
    if (a_ready !== 1'b0 || ret_pc !== 64'h300) begin
      n_err++;
      $display("FAIL reset_setup: a_ready=%0b ret_pc=%0h, required a_ready=0 ret_pc=300", a_ready, ret_pc);
    end
    #2 rst_n = 1'b0;
    #1;
    nm = '{"rst_rf_wen", "rst_sb_clr", "rst_ret_valid", "rst_rf_wdst", "rst_rf_wdata",
           "rst_ret_pc", "rst_ret_src", "rst_ret_count", "rst_a_ready", "rst_b_ready"};
    g  = '{64'(rf_wen), 64'(sb_clr), 64'(ret_valid), 64'(rf_wdst), rf_wdata,
           ret_pc, 64'(ret_src), ret_count, 64'(a_ready), 64'(b_ready)};
    w  = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd1};
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (g[i] !== w[i]) begin
        n_err++;
        $display("FAIL %s: got %0h required %0h", nm[i], g[i], w[i]);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (ret_valid !== 1'b0 || ret_count !== 64'd0 || d4_ret_count !== 4'd0) begin
        n_err++;
        $display("FAIL rst_flush c%0d: ret_valid=%0b ret_count=%0h pc=%0h, required 0/0", c, ret_valid, ret_count, ret_pc);
      end
    end
  endtask

  task automatic test_single_port;
    string       nm [9];
    logic [63:0] g  [9];
    logic [63:0] w  [9];
    do_reset();
    a_valid = 1; a_dst = 5'd5; a_result = 64'h1234; a_pc = 64'h8000_0000; a_wb_en = 1;
    tick();
    drive_idle();
    nm = '{"sp_rf_wen", "sp_rf_wdst", "sp_rf_wdata", "sp_sb_clr", "sp_sb_clr_dst",
           "sp_ret_pc", "sp_ret_valid", "sp_ret_src", "sp_ret_count"};
    g  = '{64'(rf_wen), 64'(rf_wdst), rf_wdata, 64'(sb_clr), 64'(sb_clr_dst),
           ret_pc, 64'(ret_valid), 64'(ret_src), ret_count};
    w  = '{64'd1, 64'd5, 64'h1234, 64'd1, 64'd5, 64'h8000_0000, 64'd1, 64'd0, 64'd1};
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (g[i] !== w[i]) begin
        n_err++;
        $display("FAIL %s: got %0h required %0h", nm[i], g[i], w[i]);
      end
    end
    tick();
    n_cmp++;
    if (ret_valid !== 1'b0 || rf_wen !== 1'b0 || rf_wdata !== 64'h1234) begin
      n_err++;
      $display("FAIL sp_idle: ret_valid=%0b rf_wen=%0b rf_wdata=%0h, required 0/0/1234", ret_valid, rf_wen, rf_wdata);
    end
  endtask

  task automatic test_x0;
    b_valid = 1; b_dst = 5'd0; b_result = 64'hDEAD; b_pc = 64'h44; b_wb_en = 1;
    tick();
    drive_idle();
    n_cmp++;
    if (rf_wen !== 1'b0 || sb_clr !== 1'b0 || ret_valid !== 1'b1 || ret_src !== 1'b1 ||
        ret_pc !== 64'h44 || ret_count !== 64'd2) begin
      n_err++;
      $display("FAIL x0: wen=%0b clr=%0b rv=%0b src=%0b pc=%0h cnt=%0d, required 0/0/1/1/44/2",
               rf_wen, sb_clr, ret_valid, ret_src, ret_pc, ret_count);
    end
    a_valid = 1; a_dst = 5'd7; a_result = 64'h77; a_pc = 64'h48; a_wb_en = 0;
    tick();
    drive_idle();
    n_cmp++;
    if (rf_wen !== 1'b0 || sb_clr !== 1'b0 || ret_valid !== 1'b1 || ret_src !== 1'b0) begin
      n_err++;
      $display("FAIL no_wb_en: wen=%0b clr=%0b rv=%0b src=%0b, required 0/0/1/0", rf_wen, sb_clr, ret_valid, ret_src);
    end
  endtask

  task automatic test_contention;
    do_reset();
    a_valid = 1; a_dst = 5'd1; a_pc = 64'hA0; a_result = 64'hAA; a_wb_en = 1;
    b_valid = 1; b_dst = 5'd2; b_pc = 64'hB0; b_result = 64'hBB; b_wb_en = 1;
    tick();
    drive_idle();
    n_cmp++;
    if (ret_valid !== 1 || ret_src !== 0 || ret_pc !== 64'hA0 || b_ready !== 0 || a_ready !== 1) begin
      n_err++;
      $display("FAIL cont_t1: rv=%0b src=%0b pc=%0h b_ready=%0b a_ready=%0b, required 1/0/a0/0/1",
               ret_valid, ret_src, ret_pc, b_ready, a_ready);
    end
    tick();
    n_cmp++;
    if (ret_valid !== 1 || ret_src !== 1 || ret_pc !== 64'hB0 || rf_wdata !== 64'hBB || rf_wdst !== 5'd2) begin
      n_err++;
      $display("FAIL cont_t2: rv=%0b src=%0b pc=%0h data=%0h dst=%0d, required 1/1/b0/bb/2",
               ret_valid, ret_src, ret_pc, rf_wdata, rf_wdst);
    end
    tick();
    n_cmp++;
    if (b_ready !== 1 || ret_valid !== 0 || ret_count !== 64'd2) begin
      n_err++;
      $display("FAIL cont_t3: b_ready=%0b rv=%0b cnt=%0d, required 1/0/2", b_ready, ret_valid, ret_count);
    end
  endtask

  task automatic test_sustained;
    logic [63:0] exp_a [$];
    logic [63:0] exp_b [$];
    logic [63:0] pc_a, pc_b, want;
    logic        prev_src;
    int          grants, gr_a, gr_b;
    do_reset();
    pc_a = 64'h1000; pc_b = 64'h2000;
    grants = 0; gr_a = 0; gr_b = 0; prev_src = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (ret_valid) begin
        grants++;
        if (cyc <= 20) begin
          if (ret_src) gr_b++; else gr_a++;
          n_cmp++;
          if (ret_src === prev_src) begin
            n_err++;
            $display("FAIL sus_alternate c%0d: src=%0b repeated", cyc, ret_src);
          end
        end
        prev_src = ret_src;
        want = 64'hX;
        if (ret_src == 1'b0 && exp_a.size() > 0) want = exp_a.pop_front();
        if (ret_src == 1'b1 && exp_b.size() > 0) want = exp_b.pop_front();
        n_cmp++;
        if (ret_pc !== want) begin
          n_err++;
          $display("FAIL sus_pc c%0d: got %0h required %0h", cyc, ret_pc, want);
        end
      end
      if (cyc < 20) begin
        a_valid = 1; a_dst = 5'd9; a_result = pc_a; a_pc = pc_a; a_wb_en = 1;
        b_valid = 1; b_dst = 5'd10; b_result = pc_b; b_pc = pc_b; b_wb_en = 1;
        if (a_ready) begin exp_a.push_back(pc_a); pc_a += 64'd4; end
        if (b_ready) begin exp_b.push_back(pc_b); pc_b += 64'd4; end
      end else begin
        drive_idle();
      end
      tick();
    end
    n_cmp++;
    if (gr_a != 10 || gr_b != 10) begin
      n_err++;
      $display("FAIL sus_throughput: a=%0d b=%0d, required 10/10", gr_a, gr_b);
    end
    n_cmp++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_err++;
      $display("FAIL sus_lost: left a=%0d b=%0d, required 0/0", exp_a.size(), exp_b.size());
    end
    n_cmp++;
    if (ret_count !== 64'(grants) || d4_ret_count !== 4'(grants)) begin
      n_err++;
      $display("FAIL sus_count: got %0d/%0d required %0d", ret_count, d4_ret_count, grants);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      a_valid = 1; a_dst = 5'd1; a_result = 64'(i); a_pc = 64'(i * 4); a_wb_en = 1;
      tick();
    end
    drive_idle();
    tick();
    n_cmp++;
    if (d4_ret_count !== 4'd1 || ret_count !== 64'd17) begin
      n_err++;
      $display("FAIL wrap: cnt4=%0d cnt64=%0d, required 1/17", d4_ret_count, ret_count);
    end
  endtask

  task automatic test_random;
    beat_t       qa [$];
    beat_t       qb [$];
    beat_t       cur_a, cur_b, win;
    logic        hold_a, hold_b, last, exp_vld, exp_src, exp_wen;
    logic        ha, hb, g;
    int unsigned cnt;
    do_reset();
    last = 1'b1; cnt = 0; exp_vld = 0; exp_src = 0; exp_wen = 0; win = '0;
    hold_a = 0; hold_b = 0; cur_a = '0; cur_b = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_cmp++;
      if (a_ready !== (qa.size() == 0) || b_ready !== (qb.size() == 0)) begin
        n_err++;
        $display("FAIL rnd_ready c%0d: a=%0b b=%0b, required %0b/%0b", cyc, a_ready, b_ready,
                 qa.size() == 0, qb.size() == 0);
      end
      n_cmp++;
      if (ret_valid !== exp_vld || rf_wen !== exp_wen || sb_clr !== exp_wen ||
          ret_count !== 64'(cnt) || d4_ret_count !== 4'(cnt)) begin
        n_err++;
        $display("FAIL rnd_pulse c%0d: rv=%0b wen=%0b clr=%0b cnt=%0d, required %0b/%0b/%0b/%0d",
                 cyc, ret_valid, rf_wen, sb_clr, ret_count, exp_vld, exp_wen, exp_wen, cnt);
      end
      if (exp_vld) begin
        n_cmp++;
        if (ret_src !== exp_src || ret_pc !== win.pc || rf_wdata !== win.result ||
            rf_wdst !== win.dst || sb_clr_dst !== win.dst) begin
          n_err++;
          $display("FAIL rnd_data c%0d: src=%0b pc=%0h data=%0h dst=%0d, required %0b/%0h/%0h/%0d",
                   cyc, ret_src, ret_pc, rf_wdata, rf_wdst, exp_src, win.pc, win.result, win.dst);
        end
      end
      // New stimulus; a beat that was not accepted is held until it is.
      if (!hold_a) begin
        a_valid = ($urandom_range(0, 9) < 6);
        cur_a.dst = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        cur_a.result = {$urandom, $urandom};
        cur_a.pc = {$urandom, $urandom};
        cur_a.wb_en = 1'($urandom);
      end
      if (!hold_b) begin
        b_valid = ($urandom_range(0, 9) < 6);
        cur_b.dst = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        cur_b.result = {$urandom, $urandom};
        cur_b.pc = {$urandom, $urandom};
        cur_b.wb_en = 1'($urandom);
      end
      a_dst = cur_a.dst; a_result = cur_a.result; a_pc = cur_a.pc; a_wb_en = cur_a.wb_en;
      b_dst = cur_b.dst; b_result = cur_b.result; b_pc = cur_b.pc; b_wb_en = cur_b.wb_en;
      // Reference: a port accepts only while nothing of its own is pending.
      hold_a = a_valid && (qa.size() != 0);
      hold_b = b_valid && (qb.size() != 0);
      if (a_valid && qa.size() == 0) qa.push_back(cur_a);
      if (b_valid && qb.size() == 0) qb.push_back(cur_b);
      ha = (qa.size() != 0);
      hb = (qb.size() != 0);
      exp_vld = ha || hb;
      if (exp_vld) begin
        g = (ha && hb) ? !last : hb;
        win = g ? qb.pop_front() : qa.pop_front();
        last = g;
        exp_src = g;
        exp_wen = win.wb_en && (win.dst != 5'd0);
        cnt++;
      end else begin
        exp_wen = 1'b0;
      end
      tick();
    end
    drive_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();
    #1;
    test_reset();
    test_single_port();
    test_x0();
    test_contention();
    test_sustained();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
